// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR sequence source and sampler.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_PRESENT = 2'd2
  } samp_state_e;

  localparam int unsigned CNT_W = 8;

  localparam logic [7:0]  TAPS_W8  = 8'h8E;
  localparam logic [15:0] TAPS_W16 = 16'hD008;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

  // Default Fibonacci tap mask for the supported widths; zero means "supply your own".
  function automatic logic [31:0] default_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      8:       taps = {24'd0, TAPS_W8};
      16:      taps = {16'd0, TAPS_W16};
      32:      taps = TAPS_W32;
      default: taps = 32'd0;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR register with seed load, zero-seed substitution, lockup flag and wrap detection.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned           WIDTH    = 8,
  parameter logic [WIDTH-1:0]      TAPS     = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0]      SEED     = '1,
  parameter int unsigned           SAMPLE_W = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic [WIDTH-1:0]    load_val_i,
  input  logic                step_i,
  output logic [WIDTH-1:0]    lfsr_o,
  output logic [SAMPLE_W-1:0] sample_next_o,
  output logic                wrap_o,
  output logic                lockup_o
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] next_lfsr;
  logic [WIDTH-1:0] load_val;
  logic             load_zero;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  assign next_lfsr = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign load_zero = (load_val_i == '0);
  assign load_val  = load_zero ? SEED : load_val_i;

  // Next-state: a load beats a step; wrap is flagged only for a step landing on the start value.
  always_comb begin
    lfsr_d   = lfsr_q;
    start_d  = start_q;
    lockup_d = lockup_q;
    wrap_d   = 1'b0;
    if (load_i) begin
      lfsr_d   = load_val;
      start_d  = load_val;
      lockup_d = lockup_q | load_zero;
    end else if (step_i) begin
      lfsr_d = next_lfsr;
      wrap_d = (next_lfsr == start_q);
    end
  end

  // State register with synchronous reset to the seed.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q   <= SEED;
      start_q  <= SEED;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      start_q  <= start_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign lfsr_o        = lfsr_q;
  assign sample_next_o = next_lfsr[SAMPLE_W-1:0];
  assign wrap_o        = wrap_q;
  assign lockup_o      = lockup_q;

endmodule

// File: rtl/lfsr_sampler.sv
// LFSR sequence source with a request/valid sample port that skips SKIP steps per sample.
module lfsr_sampler
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED     = '1,
  parameter int unsigned      SAMPLE_W = 4,
  parameter int unsigned      SKIP     = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                seed_load_i,
  input  logic [WIDTH-1:0]    seed_in_i,
  input  logic                sample_req_i,
  input  logic                sample_ready_i,
  output logic                sample_valid_o,
  output logic [SAMPLE_W-1:0] sample_data_o,
  output logic                busy_o,
  output logic [WIDTH-1:0]    state_out_o,
  output logic                wrap_o,
  output logic                lockup_o
);

  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP - 1);

  samp_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic [WIDTH-1:0]    state_out_q;
  logic [WIDTH-1:0]    lfsr;
  logic [SAMPLE_W-1:0] sample_next;
  logic                step;

  assign step = enable_i | (state_q == ST_SKIP);

  lfsr_core #(
    .WIDTH    (WIDTH),
    .TAPS     (TAPS),
    .SEED     (SEED),
    .SAMPLE_W (SAMPLE_W)
  ) u_core (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .load_i        (seed_load_i),
    .load_val_i    (seed_in_i),
    .step_i        (step),
    .lfsr_o        (lfsr),
    .sample_next_o (sample_next),
    .wrap_o        (wrap_o),
    .lockup_o      (lockup_o)
  );

  // Sampler FSM: count SKIP steps, capture the last step's low bits, hold until accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_req_i) begin
          state_d = ST_SKIP;
          cnt_d   = '0;
        end
      end
      ST_SKIP: begin
        if (seed_load_i) begin
          cnt_d = '0;
        end else if (cnt_q == SKIP_LAST) begin
          data_d  = sample_next;
          cnt_d   = '0;
          state_d = ST_PRESENT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESENT: begin
        if (sample_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers; reset aborts any sample in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      state_out_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      state_out_q <= lfsr;
    end
  end

  assign sample_valid_o = (state_q == ST_PRESENT);
  assign busy_o         = (state_q != ST_IDLE);
  assign sample_data_o  = data_q;
  assign state_out_o    = state_out_q;

endmodule

// File: tb/tb_lfsr_sampler.sv
// Randomized and directed bench for lfsr_sampler against a step-counting reference model.
module tb_lfsr_sampler;

  localparam int unsigned W    = 8;
  localparam int unsigned SW   = 4;
  localparam int unsigned SKIP = 3;
  localparam int          TAPS = 8'h8E;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          seed_load = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic          sample_req = 1'b0;
  logic          sample_ready = 1'b0;
  logic          sample_valid;
  logic [SW-1:0] sample_data;
  logic          busy;
  logic [W-1:0]  state_out;
  logic          wrap;
  logic          lockup;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 drawing (m_left steps still owed), 2 holding a sample.
  int m_lfsr, m_start, m_so, m_data, m_wrap, m_lock, m_mode, m_left;

  lfsr_sampler #(
    .WIDTH    (W),
    .TAPS     (8'h8E),
    .SEED     (8'hFF),
    .SAMPLE_W (SW),
    .SKIP     (SKIP)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .enable_i       (enable),
    .seed_load_i    (seed_load),
    .seed_in_i      (seed_in),
    .sample_req_i   (sample_req),
    .sample_ready_i (sample_ready),
    .sample_valid_o (sample_valid),
    .sample_data_o  (sample_data),
    .busy_o         (busy),
    .state_out_o    (state_out),
    .wrap_o         (wrap),
    .lockup_o       (lockup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int v);
    int fb = 0;
    for (int i = 0; i < int'(W); i++)
      if (((TAPS >> i) & 1) != 0) fb ^= (v >> i) & 1;
    return ((v << 1) | fb) & 'hFF;
  endfunction

  task automatic model_update();
    int om = m_mode;
    int v, nxt;
    if (reset) begin
      m_lfsr = 'hFF; m_start = 'hFF; m_so = 0; m_data = 0;
      m_wrap = 0; m_lock = 0; m_mode = 0; m_left = 0;
    end else begin
      m_so   = m_lfsr;
      m_wrap = 0;
      if (seed_load) begin
        v = (seed_in == 0) ? 'hFF : int'(seed_in);
        if (seed_in == 0) m_lock = 1;
        m_lfsr  = v;
        m_start = v;
        if (om == 1) m_left = SKIP;
      end else if (enable || om == 1) begin
        nxt    = lfsr_next(m_lfsr);
        m_wrap = (nxt == m_start) ? 1 : 0;
        m_lfsr = nxt;
        if (om == 1) begin
          m_left--;
          if (m_left == 0) begin
            m_data = nxt & ((1 << SW) - 1);
            m_mode = 2;
          end
        end
      end
      if (om == 0 && sample_req) begin
        m_mode = 1;
        m_left = SKIP;
      end
      if (om == 2 && sample_ready) m_mode = 0;
    end
  endtask

  task automatic compare_all();
    chk("valid",     sample_valid, (m_mode == 2) ? 1 : 0);
    chk("busy",      busy,         (m_mode != 0) ? 1 : 0);
    chk("data",      sample_data,  m_data);
    chk("state_out", state_out,    m_so);
    chk("wrap",      wrap,         m_wrap);
    chk("lockup",    lockup,       m_lock);
  endtask

  // One clock: model and DUT advance on the same edge, compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    reset = 1'b0; enable = 1'b0; seed_load = 1'b0; seed_in = '0;
    sample_req = 1'b0; sample_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    m_lfsr = 'hFF; m_start = 'hFF; m_so = 0; m_data = 0;
    m_wrap = 0; m_lock = 0; m_mode = 0; m_left = 0;

    // Reset state
    do_reset();
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state_out", state_out, 0);
    chk("rst_lockup", lockup, 0);

    // Free run: FF,FE,FC,F9 and a full period of 255 steps before wrap
    enable = 1'b1;
    n = 0;
    tick(); n++;
    chk("free_so0", state_out, 8'hFF);
    tick(); n++;
    chk("free_so1", state_out, 8'hFE);
    tick(); n++;
    chk("free_so2", state_out, 8'hFC);
    tick(); n++;
    chk("free_so3", state_out, 8'hF9);
    while (wrap !== 1'b1 && n < 300) begin
      tick(); n++;
    end
    chk("period", n, 255);
    tick();
    chk("wrap_single", wrap, 0);

    // Zero seed substitution and sticky lockup
    enable = 1'b0; seed_load = 1'b1; seed_in = 8'h00;
    tick();
    seed_load = 1'b0;
    chk("zero_lockup", lockup, 1);
    tick();
    chk("zero_lfsr", state_out, 8'hFF);
    enable = 1'b1;
    repeat (5) tick();
    chk("lockup_sticky", lockup, 1);

    // Sample with enable=0 from FF: FE,FC,F9 -> data 9 on the 3rd edge after acceptance
    do_reset();
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    chk("req_busy", busy, 1);
    tick();
    tick();
    chk("valid_not_early", sample_valid, 0);
    tick();
    chk("sample_valid", sample_valid, 1);
    chk("sample_data", sample_data, 4'h9);

    // Backpressure: 10 cycles of ready=0 with stray requests
    for (int i = 0; i < 10; i++) begin
      sample_req = i[0];
      enable = ~i[0];
      tick();
    end
    sample_req = 1'b0; enable = 1'b0;
    chk("bp_data", sample_data, 4'h9);
    chk("bp_busy", busy, 1);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    chk("bp_drop", sample_valid, 0);
    chk("bp_idle", busy, 0);

    // Seed 01 on the 2nd draw cycle: steps 02,05,0B -> data B
    do_reset();
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    tick();
    seed_load = 1'b1; seed_in = 8'h01;
    tick();
    seed_load = 1'b0;
    tick();
    tick();
    chk("mid_seed_not_yet", sample_valid, 0);
    tick();
    chk("mid_seed_valid", sample_valid, 1);
    chk("mid_seed_data", sample_data, 4'hB);

    // Reset while presenting, with lockup set beforehand
    seed_load = 1'b1; seed_in = 8'h00;
    tick();
    seed_load = 1'b0;
    chk("pre_rst_lockup", lockup, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_present_valid", sample_valid, 0);
    chk("rst_present_busy", busy, 0);
    chk("rst_present_lockup", lockup, 0);
    tick();
    chk("rst_present_lfsr", state_out, 8'hFF);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      enable       = $urandom_range(0, 1) == 1;
      seed_load    = ($urandom_range(0, 19) == 0);
      seed_in      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      sample_req   = ($urandom_range(0, 2) == 0);
      sample_ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
